// File: rtl/div_sequencer_pkg.sv
// Shared constants and types for the RV32IM divide sequencer.
package div_sequencer_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All four divide-class codes share funct3[2] = 1.
    function automatic logic f3_valid(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring radix-2 divider datapath: operand latch, shift-subtract step, sign fix.
module div_datapath
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            abs_ops,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor_in,
    input  logic            step,
    input  logic            fix,
    input  logic            sel_rem,
    input  logic            negate,
    input  logic            special,
    input  logic [XLEN-1:0] special_val,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic [XLEN-1:0] quo_sh, op1_abs, op2_abs, fix_sel, fix_val;
    logic            rem_ge;

    // Operand magnitudes, shift-subtract step and final sign correction.
    always_comb begin
        op1_abs = (abs_ops && dividend[XLEN-1])   ? -dividend   : dividend;
        op2_abs = (abs_ops && divisor_in[XLEN-1]) ? -divisor_in : divisor_in;
        // The shifted remainder is one bit wider so the compare never overflows.
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        quo_sh  = {quo_q[XLEN-2:0], 1'b0};
        rem_ge  = rem_sh >= {1'b0, dvs_q};
        rem_sub = rem_sh - {1'b0, dvs_q};
        fix_sel = sel_rem ? rem_q : quo_q;
        fix_val = negate ? -fix_sel : fix_sel;
    end

    // Working registers and the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                rem_q <= '0;
                quo_q <= op1_abs;
                dvs_q <= op2_abs;
            end else if (step) begin
                rem_q <= rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_q <= {quo_sh[XLEN-1:1], rem_ge};
            end
            if (fix) begin
                result_q <= fix_val;
            end else if (special) begin
                result_q <= special_val;
            end
        end
    end

    assign result = result_q;

endmodule

// File: rtl/div_sequencer.sv
// EX-stage sequencer for DIV/DIVU/REM/REMU: FSM, iteration counter,
// special-case short cuts and pipeline stall request.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no op in flight; may accept a new op
//   ST_CALC | one shift-subtract step per cycle, XLEN steps
//   ST_FIX  | select quotient/remainder, apply sign, load result
//   ST_DONE | done pulse; result valid; may accept a back-to-back op
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sel_rem_q, signed_q, qneg_q, rneg_q;
    logic [4:0]       rd_q, rd_out_q;
    logic             accept, div_zero, ovf, special, step, fix, negate;
    logic [XLEN-1:0]  special_val;

    // Acceptance, special-case detection, next state and datapath controls.
    always_comb begin
        accept   = start && !flush && f3_valid(funct3) &&
                   (state_q == ST_IDLE || state_q == ST_DONE);
        div_zero = (operand2 == '0);
        ovf      = f3_signed(funct3) && (operand1 == INT_MIN) && (operand2 == '1);
        special  = div_zero || ovf;
        if (div_zero) begin
            special_val = f3_is_rem(funct3) ? operand1 : '1;
        end else begin
            special_val = f3_is_rem(funct3) ? '0 : INT_MIN;
        end
        step    = 1'b0;
        fix     = 1'b0;
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_d = special ? ST_DONE : ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    fix     = 1'b1;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        negate = signed_q && (sel_rem_q ? rneg_q : qneg_q);
        busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
        done   = (state_q == ST_DONE);
        // Combinational from start so the accepting cycle itself is frozen.
        stall  = accept || busy;
    end

    // State register, iteration counter, op-type/sign latch and destination register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            signed_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rd_q      <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q     <= '0;
                sel_rem_q <= f3_is_rem(funct3);
                signed_q  <= f3_signed(funct3);
                qneg_q    <= operand1[XLEN-1] ^ operand2[XLEN-1];
                rneg_q    <= operand1[XLEN-1];
                rd_q      <= rd_in;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept && special) begin
                rd_out_q <= rd_in;
            end else if (fix) begin
                rd_out_q <= rd_q;
            end
        end
    end

    div_datapath #(.XLEN(XLEN)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .abs_ops     (f3_signed(funct3)),
        .dividend    (operand1),
        .divisor_in  (operand2),
        .step        (step),
        .fix         (fix),
        .sel_rem     (sel_rem_q),
        .negate      (negate),
        .special     (accept && special),
        .special_val (special_val),
        .result      (result)
    );

    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results are queued at issue
// and compared whenever the DUT pulses done.
module tb_div_sequencer;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operand1, operand2;
    logic [4:0]  rd_in;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [36:0] exp_q[$];
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .operand1 (operand1),
        .operand2 (operand2),
        .rd_in    (rd_in),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic special_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sr;
        sa = a;
        sb = b;
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3)
            F3_DIV:  begin sr = sa / sb; return sr; end
            F3_DIVU: return a / b;
            F3_REM:  begin sr = sa % sb; return sr; end
            default: return a % b;
        endcase
    endfunction

    // Drive one op for a single cycle and follow it until its done pulse.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
        int   done_cyc;
        logic stall_bad;
        funct3   = f3;
        operand1 = a;
        operand2 = b;
        rd_in    = rd;
        start    = 1'b1;
        #1;
        exp_q.push_back({rd, exp_res});
        chk("stall_c0", stall, 1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_cyc  = 0;
        stall_bad = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                chk("stall_done", stall, 0);
                break;
            end
            if (!stall) stall_bad = 1'b1;
        end
        chk("latency", done_cyc, exp_lat);
        chk("stall_held", stall_bad, 0);
        last_res = exp_res;
        last_rd  = rd;
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            chk("done_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("result", result, e[31:0]);
                chk("rd_out", rd_out, e[36:32]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        seen;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; operand1 = '0; operand2 = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done",   done,   0);
        chk("rst_busy",   busy,   0);
        chk("rst_stall",  stall,  0);
        chk("rst_result", result, 0);
        chk("rst_rd_out", rd_out, 0);

        // Non-divide funct3 with start is ignored.
        @(posedge clk); #1;
        funct3 = 3'b000; operand1 = 32'd10; operand2 = 32'd2; start = 1'b1;
        #1;
        chk("bad_f3_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("bad_f3_busy", busy, 0);

        @(posedge clk); #1;
        run_op(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
        @(posedge clk); #1;
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'h2, 5'd6, 32'hFFFF_FFFD, 34);
        @(posedge clk); #1;
        run_op(F3_REM, 32'hFFFF_FFF9, 32'h2, 5'd7, 32'hFFFF_FFFF, 34);
        @(posedge clk); #1;
        run_op(F3_DIV, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        @(posedge clk); #1;
        run_op(F3_REMU, 32'd5, 32'd0, 5'd9, 32'd5, 1);
        @(posedge clk); #1;
        run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        @(posedge clk); #1;
        run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 1);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
            @(posedge clk); #1;
            run_op(f3, a, b, 5'(i + 16), ref_res(f3, a, b), special_case(f3, a, b) ? 1 : 34);
        end

        @(posedge clk); #1;
        run_op(F3_DIVU, 32'd1000, 32'd7, 5'd11, 32'd142, 34);

        // Flush in cycle 10 of a DIVU.
        @(posedge clk); #1;
        funct3 = F3_DIVU; operand1 = 32'd5000; operand2 = 32'd3; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", stall, 0);
        chk("flush_busy",  busy,  0);
        seen = done;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("flush_no_done", seen, 0);
        chk("flush_result",  result, last_res);
        chk("flush_rd_out",  rd_out, last_rd);

        // Reset in cycle 20 of an op.
        @(posedge clk); #1;
        funct3 = F3_DIV; operand1 = 32'd777; operand2 = 32'd5; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_done",   done,   0);
        chk("mid_rst_busy",   busy,   0);
        chk("mid_rst_stall",  stall,  0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_rd_out", rd_out, 0);

        // New op after reset, then a back-to-back start in its done cycle.
        @(posedge clk); #1;
        run_op(F3_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 34);
        run_op(F3_DIVU, 32'd1000, 32'd10, 5'd10, 32'd100, 34);

        @(posedge clk); #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for the RV32IM DIV/DIVU/REM/REMU instructions, in the EX stage beside the single-cycle ALU.
- Latches the operands and runs an iterative radix-2 restoring divider, one quotient bit per cycle.
- Holds a stall request to the pipeline hazard logic until the result is ready, then presents the result with the destination register for writeback.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (≥ clog2(XLEN)+1).

Ports:
- CLK  in  1  system clock; everything is updated on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  issue request; EX holds a DIV-class op this cycle.
- FLUSH  in  1  synchronous abort from a branch/jump flush.
- FUNCT3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes with START raised are ignored.
- OPERAND1  in  XLEN  dividend (rs1).
- OPERAND2  in  XLEN  divisor (rs2).
- RD_IN  in  5  destination register of the issued op.
- STALL  out  1  freeze IF/ID/EX while an op is being accepted or is in progress.
- BUSY  out  1  state is CALC or FIX.
- DONE  out  1  one-cycle pulse; RESULT and RD_OUT are valid.
- RESULT  out  XLEN  quotient or remainder.
- RD_OUT  out  5  destination register for writeback.

Behaviour:
- Reset: on a rising CLK edge with RESET=1:
  - state goes to IDLE;
  - DONE, BUSY, RESULT, RD_OUT and all internal registers go to 0.
  - RESET overrides FLUSH and START, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- Accepting an op: in IDLE or DONE, with START=1, FLUSH=0 and a valid FUNCT3, the edge:
  - latches the operands (absolute values for signed ops), the op type and RD_IN;
  - records the quotient sign (op1[31]^op2[31]) and the remainder sign (op1[31]);
  - clears the counter.
- Next state after acceptance:
  - divisor == 0: DONE. RESULT = all ones (DIV/DIVU) or OPERAND1 (REM/REMU).
  - DIV/REM with OPERAND1 = 0x8000_0000 and OPERAND2 = 0xFFFF_FFFF: DONE. RESULT = 0x8000_0000 (DIV) or 0 (REM).
  - Otherwise: CALC.
- CALC: each edge does one shift-subtract step:
  - shift {rem, quo} left by 1;
  - if rem ≥ divisor, subtract the divisor and set quo[0] = 1;
  - counter increments; after XLEN iterations (counter == XLEN-1 at the edge) go to FIX.
- FIX: one edge selects the quotient or remainder, negates it if the recorded sign requires (signed ops only), loads RESULT, and goes to DONE.
- DONE: DONE=1 for exactly this cycle.
  - Next edge goes to IDLE, unless a new op is accepted (back-to-back).
  - RESULT and RD_OUT hold their values until the next completion.
- Latency, with START in cycle 0:
  - normal op: DONE in cycle XLEN+2 (34);
  - special case: DONE in cycle 1.
- STALL = (START & ~FLUSH & valid FUNCT3 & state∈{IDLE,DONE}) | BUSY.
  - This is combinational from START so the accepting cycle is stalled.
  - STALL is low in the DONE cycle so writeback proceeds.
- START while BUSY is ignored; the pipeline is already frozen, so this cannot occur legally.
- FLUSH=1 in any state: next state is IDLE, DONE is not raised, and RESULT/RD_OUT are unchanged. START is ignored in the same cycle.
- Arithmetic:
  - remainder register is XLEN+1 bits so the compare is unsigned with no overflow;
  - negation is two's complement modulo 2^XLEN;
  - the remainder takes the sign of the dividend (RISC-V semantics).

Decomposition:
- Shared package/header holds:
  - FUNCT3 codes DIV/DIVU/REM/REMU;
  - state encodings IDLE=0, CALC=1, FIX=2, DONE=3;
  - XLEN.
- One natural sub-module: div_datapath. It holds the rem/quo/divisor registers, the shift-subtract step and the sign fix.
- div_sequencer keeps the FSM, counter, special-case detection and stall logic.

Test Plan:
- DIVU 100/7, START one cycle → STALL high in cycles 0–33, DONE only in cycle 34, RESULT = 14, RD_OUT echoes RD_IN.
- DIV and REM of -7 by 2 (0xFFFF_FFF9, 0x2), issued as two separate ops → first DONE with RESULT = 0xFFFF_FFFD (-3); second DONE with RESULT = 0xFFFF_FFFF (-1).
- Divide-by-zero: DIV 5/0 → DONE in cycle 1 with RESULT = 0xFFFF_FFFF; REMU 5/0 → RESULT = 5; STALL high only in cycle 0.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF → DONE in cycle 1 with RESULT = 0x8000_0000; REM of the same operands → RESULT = 0.
- FLUSH in cycle 10 of a DIVU → IDLE next cycle, STALL/BUSY low, no DONE pulse for 50 cycles, RESULT keeps its prior value.
- RESET in cycle 20 of an op → next cycle all outputs 0, state IDLE. A new DIVU 9/3 issued afterwards → RESULT = 3 at +34. A back-to-back START in the DONE cycle is accepted.
